// File: rtl/dual_port_dmem.sv
// dual_port_dmem: two-port data memory for the dual-issue core.
// 256-word RAM (addr[8]=0), MMIO page at 0x100 (LED, SW, CYC, SCR) and an
// optional post-reset clear sequencer, enabled by defining DM_INIT_CLEAR_EN.
// Same-cycle conflicts between the ports resolve in favour of p1.
module dual_port_dmem #(
   parameter int DEPTH = 256,
   parameter int SW_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [8:0]       p0_maddr,
   input  logic [15:0]      p0_wdata,
   input  logic             p0_write_mem,
   output logic [15:0]      p0_rdata,
   input  logic [8:0]       p1_maddr,
   input  logic [15:0]      p1_wdata,
   input  logic             p1_write_mem,
   output logic [15:0]      p1_rdata,
   input  logic [SW_W-1:0]  sw_in,
   output logic [15:0]      led_out,
   output logic             mem_ready
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [8:0] A_LED = 9'h100;
   localparam logic [8:0] A_SW  = 9'h101;
   localparam logic [8:0] A_CYC = 9'h102;
   localparam logic [8:0] A_SCR = 9'h103;

   logic [15:0]   mem [DEPTH];
   logic [15:0]   scr, cyc;
   logic [15:0]   sw_ext;
   logic [15:0]   ram_q0, ram_q1;
   logic [15:0]   rd0_nx, rd1_nx;
   logic          ram_en;    // RAM port accesses are live (not clearing)
   logic          clr_we;
   logic [AW-1:0] clr_ptr;
   logic          p0_ram_we, p1_ram_we, same_idx;

   assign sw_ext = 16'(sw_in);
   assign ram_q0 = mem[p0_maddr[AW-1:0]];
   assign ram_q1 = mem[p1_maddr[AW-1:0]];

   assign p0_ram_we = ram_en && p0_write_mem && !p0_maddr[8];
   assign p1_ram_we = ram_en && p1_write_mem && !p1_maddr[8];
   assign same_idx  = (p0_maddr[AW-1:0] == p1_maddr[AW-1:0]);

`ifdef DM_INIT_CLEAR_EN
   typedef enum logic {S_CLEAR, S_READY} state_t;
   state_t        state, state_nx;
   logic [AW-1:0] ptr;

   // state register and clear pointer; reset always restarts the sweep at 0
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_nx;
         if (state == S_CLEAR) ptr <= ptr + 1'b1;
      end
   end

   // leave CLEAR once the last word has been zeroed
   always_comb begin
      state_nx = state;
      case (state)
         S_CLEAR: if (ptr == AW'(DEPTH - 1)) state_nx = S_READY;
         S_READY: state_nx = S_READY;
         default: state_nx = S_CLEAR;
      endcase
   end

   assign ram_en    = (state == S_READY);
   assign mem_ready = (state == S_READY);
   assign clr_we    = rst && (state == S_CLEAR);
   assign clr_ptr   = ptr;
`else
   logic rdy_q;

   // no sweep: ready one cycle after reset release
   always_ff @(posedge clk) begin
      if (!rst) rdy_q <= 1'b0;
      else      rdy_q <= 1'b1;
   end

   assign ram_en    = 1'b1;
   assign mem_ready = rdy_q;
   assign clr_we    = 1'b0;
   assign clr_ptr   = '0;
`endif

   // true when a write of wa this cycle lands on the location read at ra
   function automatic logic wr_hit(input logic [8:0] ra, input logic [8:0] wa,
                                   input logic we, input logic ram_ok);
      if (!we) return 1'b0;
      if (!wa[8]) return ram_ok && !ra[8] && (ra[AW-1:0] == wa[AW-1:0]);
      return ((wa == A_LED) || (wa == A_SCR)) && (ra == wa);
   endfunction

   // stored value of the location at a, before this cycle's writes
   function automatic logic [15:0] rd_mux(input logic [8:0] a, input logic [15:0] ram_q,
                                          input logic ram_ok, input logic [15:0] led_v,
                                          input logic [15:0] sw_v, input logic [15:0] cyc_v,
                                          input logic [15:0] scr_v);
      if (!a[8])       return ram_ok ? ram_q : 16'h0000;
      if (a == A_LED)  return led_v;
      if (a == A_SW)   return sw_v;
      if (a == A_CYC)  return cyc_v;
      if (a == A_SCR)  return scr_v;
      return 16'h0000;
   endfunction

   // write-first read data: p1's write overrides p0's, which overrides storage
   always_comb begin
      rd0_nx = rd_mux(p0_maddr, ram_q0, ram_en, led_out, sw_ext, cyc, scr);
      if (wr_hit(p0_maddr, p0_maddr, p0_write_mem, ram_en)) rd0_nx = p0_wdata;
      if (wr_hit(p0_maddr, p1_maddr, p1_write_mem, ram_en)) rd0_nx = p1_wdata;
      rd1_nx = rd_mux(p1_maddr, ram_q1, ram_en, led_out, sw_ext, cyc, scr);
      if (wr_hit(p1_maddr, p0_maddr, p0_write_mem, ram_en)) rd1_nx = p0_wdata;
      if (wr_hit(p1_maddr, p1_maddr, p1_write_mem, ram_en)) rd1_nx = p1_wdata;
   end

   // registered read ports
   always_ff @(posedge clk) begin
      if (!rst) begin
         p0_rdata <= 16'h0000;
         p1_rdata <= 16'h0000;
      end else begin
         p0_rdata <= rd0_nx;
         p1_rdata <= rd1_nx;
      end
   end

   // MMIO registers; cycle counter free-runs, RW registers favour p1
   always_ff @(posedge clk) begin
      if (!rst) begin
         led_out <= 16'h0000;
         scr     <= 16'h0000;
         cyc     <= 16'h0000;
      end else begin
         cyc <= cyc + 16'd1;
         if (p1_write_mem && p1_maddr == A_LED)      led_out <= p1_wdata;
         else if (p0_write_mem && p0_maddr == A_LED) led_out <= p0_wdata;
         if (p1_write_mem && p1_maddr == A_SCR)      scr <= p1_wdata;
         else if (p0_write_mem && p0_maddr == A_SCR) scr <= p0_wdata;
      end
   end

   // RAM array: clear sweep or port writes; no reset on the storage itself
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_ptr] <= 16'h0000;
      end else if (rst) begin
         if (p0_ram_we && !(p1_ram_we && same_idx)) mem[p0_maddr[AW-1:0]] <= p0_wdata;
         if (p1_ram_we) mem[p1_maddr[AW-1:0]] <= p1_wdata;
      end
   end

endmodule

// File: tb/tb_dual_port_dmem.sv
// Self-checking bench for dual_port_dmem: directed vectors, CLEAR/reset
// sequences, randomized traffic against a location-level model, CYC wrap.
module tb_dual_port_dmem;

   localparam int DEPTH = 256;
`ifdef DM_INIT_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [8:0]  p0_maddr = '0, p1_maddr = '0;
   logic [15:0] p0_wdata = '0, p1_wdata = '0;
   logic        p0_write_mem = 1'b0, p1_write_mem = 1'b0;
   logic [15:0] p0_rdata, p1_rdata, led_out;
   logic [7:0]  sw_in = '0;
   logic        mem_ready;

   int n_cmp = 0;
   int n_err = 0;

   dual_port_dmem #(.DEPTH(DEPTH), .SW_W(8)) dut (
      .clk(clk), .rst(rst),
      .p0_maddr(p0_maddr), .p0_wdata(p0_wdata), .p0_write_mem(p0_write_mem), .p0_rdata(p0_rdata),
      .p1_maddr(p1_maddr), .p1_wdata(p1_wdata), .p1_write_mem(p1_write_mem), .p1_rdata(p1_rdata),
      .sw_in(sw_in), .led_out(led_out), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // reference model: contents of every addressable location
   logic [15:0] m_ram [DEPTH];
   bit          m_kn  [DEPTH];
   logic [15:0] m_led = '0, m_scr = '0, m_cyc = '0;
   int          m_clr = 0;   // cycles out of reset

   function automatic bit m_rdy();
      return m_clr >= (CLR_EN ? DEPTH : 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_wr(input logic [8:0] a, input logic [15:0] d, input bit we, input bit ram_ok);
      if (!we) return;
      if (!a[8]) begin
         if (ram_ok) begin
            m_ram[int'(a[7:0]) % DEPTH] = d;
            m_kn[int'(a[7:0]) % DEPTH]  = 1'b1;
         end
      end else if (a == 9'h100) m_led = d;
      else if (a == 9'h103)     m_scr = d;
   endtask

   task automatic m_rd(input logic [8:0] a, input bit ram_ok, output logic [15:0] v, output bit k);
      k = 1'b1;
      v = 16'h0000;
      if (!a[8]) begin
         if (ram_ok) begin
            v = m_ram[int'(a[7:0]) % DEPTH];
            k = m_kn[int'(a[7:0]) % DEPTH];
         end
      end else begin
         case (a)
            9'h100:  v = m_led;
            9'h101:  v = 16'(sw_in);
            9'h102:  v = m_cyc;
            9'h103:  v = m_scr;
            default: v = 16'h0000;
         endcase
      end
   endtask

   // one clock: drive, advance model (writes land before reads), check
   task automatic step(input logic r,
                       input logic [8:0] a0, input logic [15:0] w0, input bit we0,
                       input logic [8:0] a1, input logic [15:0] w1, input bit we1);
      logic [15:0] e0, e1;
      bit k0, k1, ram_ok;
      rst = r;
      p0_maddr = a0; p0_wdata = w0; p0_write_mem = we0;
      p1_maddr = a1; p1_wdata = w1; p1_write_mem = we1;
      if (!r) begin
         e0 = '0; e1 = '0; k0 = 1'b1; k1 = 1'b1;
         m_led = '0; m_scr = '0; m_cyc = '0; m_clr = 0;
         if (CLR_EN) for (int i = 0; i < DEPTH; i++) begin m_ram[i] = '0; m_kn[i] = 1'b1; end
      end else begin
         ram_ok = CLR_EN ? m_rdy() : 1'b1;
         m_wr(a0, w0, we0, ram_ok);
         m_wr(a1, w1, we1, ram_ok);
         m_rd(a0, ram_ok, e0, k0);
         m_rd(a1, ram_ok, e1, k1);
         m_cyc = m_cyc + 16'd1;
         m_clr++;
      end
      @(posedge clk);
      @(negedge clk);
      if (k0) chk("p0_rdata", p0_rdata, e0);
      if (k1) chk("p1_rdata", p1_rdata, e1);
      chk("mem_ready", mem_ready, m_rdy() && r);
      chk("led_out", led_out, m_led);
   endtask

   task automatic idle();
      step(1'b1, 9'h1F0, '0, 1'b0, 9'h1F0, '0, 1'b0);
   endtask

   // step until mem_ready, counting samples where it was still low
   task automatic wait_ready(inout int lo);
      int g = 0;
      while (mem_ready !== 1'b1 && g < 400) begin
         idle();
         if (mem_ready !== 1'b1) lo++;
         g++;
      end
   endtask

   function automatic logic [8:0] rand_addr();
      case ($urandom_range(0, 3))
         0:       return {5'b0, 4'($urandom_range(0, 15))};
         1:       return 9'h100 + 9'($urandom_range(0, 4));
         2:       return 9'($urandom_range(0, 511));
         default: return {5'b0_1111, 4'($urandom_range(0, 15))};
      endcase
   endfunction

   typedef struct {
      logic [7:0]  sw;
      logic [8:0]  a0; logic [15:0] w0; bit we0;
      logic [8:0]  a1; logic [15:0] w1; bit we1;
      logic [15:0] e0, e1;
   } vec_t;

   vec_t vt[14];

   initial begin
      int lo;
      for (int i = 0; i < DEPTH; i++) m_kn[i] = 1'b0;
      vt[0]  = '{8'h00, 9'h020, 16'hAAAA, 1'b1, 9'h020, 16'h5555, 1'b1, 16'h5555, 16'h5555};
      vt[1]  = '{8'h00, 9'h020, 16'h0000, 1'b0, 9'h020, 16'h0000, 1'b0, 16'h5555, 16'h5555};
      vt[2]  = '{8'h00, 9'h030, 16'hBEEF, 1'b1, 9'h030, 16'h0000, 1'b0, 16'hBEEF, 16'hBEEF};
      vt[3]  = '{8'h00, 9'h030, 16'h0000, 1'b0, 9'h020, 16'h0000, 1'b0, 16'hBEEF, 16'h5555};
      vt[4]  = '{8'h3C, 9'h1F0, 16'h0000, 1'b0, 9'h101, 16'h0000, 1'b0, 16'h0000, 16'h003C};
      vt[5]  = '{8'h3C, 9'h101, 16'h0000, 1'b0, 9'h101, 16'hFFFF, 1'b1, 16'h003C, 16'h003C};
      vt[6]  = '{8'h3C, 9'h104, 16'h1234, 1'b1, 9'h101, 16'h0000, 1'b0, 16'h0000, 16'h003C};
      vt[7]  = '{8'h00, 9'h103, 16'h1111, 1'b1, 9'h103, 16'h2222, 1'b1, 16'h2222, 16'h2222};
      vt[8]  = '{8'h00, 9'h103, 16'h0000, 1'b0, 9'h100, 16'h0F0F, 1'b1, 16'h2222, 16'h0F0F};
      vt[9]  = '{8'h00, 9'h040, 16'h0001, 1'b1, 9'h041, 16'h0002, 1'b1, 16'h0001, 16'h0002};
      vt[10] = '{8'h00, 9'h041, 16'h0000, 1'b0, 9'h040, 16'h0000, 1'b0, 16'h0002, 16'h0001};
      vt[11] = '{8'h00, 9'h1FF, 16'h0000, 1'b0, 9'h100, 16'h0000, 1'b0, 16'h0000, 16'h0F0F};
      vt[12] = '{8'h00, 9'h020, 16'h0000, 1'b0, 9'h104, 16'h0000, 1'b0, 16'h5555, 16'h0000};
      vt[13] = '{8'h00, 9'h040, 16'h0000, 1'b0, 9'h040, 16'h7777, 1'b1, 16'h7777, 16'h7777};

      // reset state
      @(negedge clk);
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);

      // writes right after release: RAM write dropped while clearing, LED kept
      lo = 0;
      step(1'b1, 9'h010, 16'h1234, 1'b1, 9'h1F0, '0, 1'b0);
      if (mem_ready !== 1'b1) lo++;
      step(1'b1, 9'h100, 16'h00A5, 1'b1, 9'h101, '0, 1'b0);
      if (mem_ready !== 1'b1) lo++;
      chk("led_during_clear", led_out, 16'h00A5);
      wait_ready(lo);
      chk("ready_low_cycles", lo, CLR_EN ? DEPTH - 1 : 0);

      step(1'b1, 9'h010, '0, 1'b0, 9'h000, '0, 1'b0);
      chk("ram_010_after_clear", p0_rdata, CLR_EN ? 16'h0000 : 16'h1234);
      step(1'b1, 9'h07F, '0, 1'b0, 9'h0FF, '0, 1'b0);

      // directed vectors
      for (int i = 0; i < 14; i++) begin
         sw_in = vt[i].sw;
         step(1'b1, vt[i].a0, vt[i].w0, vt[i].we0, vt[i].a1, vt[i].w1, vt[i].we1);
         chk($sformatf("vec%0d_p0", i), p0_rdata, vt[i].e0);
         chk($sformatf("vec%0d_p1", i), p1_rdata, vt[i].e1);
      end

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         sw_in = 8'($urandom);
         step(1'b1, rand_addr(), 16'($urandom), 1'($urandom_range(0, 1)),
                    rand_addr(), 16'($urandom), 1'($urandom_range(0, 1)));
      end

      // reset in the middle of the clear sweep restarts it
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 100; i++) idle();
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      lo = 0;
      wait_ready(lo);
      chk("ready_low_after_restart", lo, CLR_EN ? DEPTH - 1 : 0);

      // counter wrap on consecutive reads
      for (int g = 0; g < 70000 && m_cyc != 16'hFFFE; g++) idle();
      step(1'b1, 9'h102, '0, 1'b0, 9'h1F0, '0, 1'b0);
      chk("cyc_fffe", p0_rdata, 16'hFFFE);
      step(1'b1, 9'h102, '0, 1'b0, 9'h1F0, '0, 1'b0);
      chk("cyc_ffff", p0_rdata, 16'hFFFF);
      step(1'b1, 9'h102, 16'h1234, 1'b1, 9'h102, '0, 1'b0);
      chk("cyc_0000", p0_rdata, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dual_port_dmem.md
Name: dual_port_dmem

Overview:
- Data-memory responder for the dual-issue core.
- Serves the two pipeline data ports (p0, p1) issued by the cpu: 9-bit word address, 16-bit write data, write strobe and 16-bit read data per port.
- Contains a 256-word RAM, a small memory-mapped I/O page (LEDs, switches, free-running cycle counter, scratch register) and a post-reset clear sequencer.
- Same-cycle conflicts between the two pipelines resolve in favour of p1, the younger instruction, matching the core's register-writeback priority.

Parameters:
DEPTH, 256, RAM words; must be a power of two, max 256; occupies addr[8]=0 space.
SW_W, 8, width of switch input; zero-extended to 16 bits on read.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
p0_maddr  input  9  pipeline 0 word address
p0_wdata  input  16  pipeline 0 write data
p0_write_mem  input  1  pipeline 0 write strobe
p0_rdata  output  16  pipeline 0 read data, registered
p1_maddr  input  9  pipeline 1 word address
p1_wdata  input  16  pipeline 1 write data
p1_write_mem  input  1  pipeline 1 write strobe
p1_rdata  output  16  pipeline 1 read data, registered
sw_in  input  SW_W  external switches
led_out  output  16  LED register contents
mem_ready  output  1  high once the clear sequence completes

Behaviour:
- Address map:
  - addr[8]=0: RAM word addr[7:0] mod DEPTH.
  - 0x100: LED, RW.
  - 0x101: SW, RO, writes ignored.
  - 0x102: CYC, RO, 16-bit free-running counter, writes ignored.
  - 0x103: SCR, RW scratch.
  - 0x104-0x1FF: reads return 0x0000, writes ignored.
- Read latency is exactly 1 cycle. p*_rdata at edge N+1 reflects the address presented in cycle N.
- Reads are sampled every cycle regardless of write strobe, so a writing port also returns data.
- Write-first semantics. If any port writes address A in cycle N, a read of A by either port in cycle N returns the newly written value.
- Dual write, same address (RAM or RW MMIO): p1_wdata is stored and both ports read back p1_wdata. Different addresses: both writes commit.
- CYC increments by 1 every cycle, wraps 0xFFFF -> 0x0000, and keeps counting during CLEAR. A CYC read in cycle N returns the pre-increment value of cycle N.
- Reset (rst=0 at an edge):
  - p0_rdata = p1_rdata = 0, led_out = 0, SCR = 0, CYC = 0, mem_ready = 0.
  - State goes to CLEAR with clear pointer 0.
  - RAM contents are not reset directly.
- State machine:
  - CLEAR: each cycle writes 0x0000 to RAM[ptr], then ptr++. When ptr = DEPTH-1 is written, move to READY next cycle. mem_ready=0 throughout.
  - CLEAR port behaviour: RAM writes from ports are dropped; MMIO writes are honoured. RAM reads return 0x0000; MMIO reads are normal.
  - READY: normal operation, mem_ready=1. Remains in READY until reset.
- Reset asserted mid-CLEAR restarts CLEAR at ptr 0. Reset in READY also re-enters CLEAR.
- Any address bits outside the decoded field are don't-care only as described above; no X propagates to outputs.

Optional Feature:
- Macro DM_INIT_CLEAR_EN.
- Defined: CLEAR sequencer present, as described above. mem_ready rises DEPTH cycles after reset release.
- Undefined: no sequencer. Reset goes straight to READY, mem_ready=1 on the first cycle after reset release, and RAM contents are unspecified (simulation X) until written. All other behaviour is unchanged.

Test Plan:
- Reset release with DM_INIT_CLEAR_EN and DEPTH=256 -> mem_ready=0 for 256 cycles then 1. Reads of RAM 0x000, 0x07F and 0x0FF all return 0x0000.
- During CLEAR, p0 writes 0x1234 to 0x010; after READY, p0 reads 0x010 -> 0x0000. p0 writes 0x00A5 to 0x100 during CLEAR -> led_out=0x00A5.
- READY, same cycle: p0 writes 0xAAAA and p1 writes 0x5555, both to 0x020 -> next-cycle p0_rdata = p1_rdata = 0x5555. Later read of 0x020 -> 0x5555.
- READY: p0 writes 0xBEEF to 0x030 while p1 reads 0x030 in the same cycle -> p1_rdata=0xBEEF one cycle later. p0_rdata=0xBEEF as well.
- sw_in=0x3C, p1 reads 0x101 -> 0x003C. p1 writes 0xFFFF to 0x101 -> ignored, reread gives 0x003C. Read of 0x1F0 -> 0x0000.
- Force CYC near wrap and read 0x102 on consecutive cycles -> 0xFFFE, 0xFFFF, 0x0000. Assert rst=0 mid-CLEAR at ptr=100 -> ptr restarts at 0, mem_ready stays 0 for a further full 256 cycles.
